// File: rtl/sha256_pkg.sv
// Shared widths, FSM state encoding and a one-hot decode helper for the
// SHA-256 request arbiter.
package sha256_pkg;

    localparam int MSG_W  = 24;
    localparam int HASH_W = 256;
    localparam int ID_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic [ID_W-1:0] onehot_idx(input logic [7:0] oh);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: the search starts one past the previous winner
// so every active requester is reached within NUM_REQ grants.
module rr_arbiter
    import sha256_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant
);

    // Rotating priority search over all requesters.
    always_comb begin
        int   idx_v;
        logic found_v;
        grant   = '0;
        found_v = 1'b0;
        idx_v   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_v = (int'(last_grant) + k) % NUM_REQ;
            if (!found_v && req[idx_v]) begin
                grant[idx_v] = 1'b1;
                found_v      = 1'b1;
            end else begin
                found_v = found_v;
            end
        end
    end

endmodule

// File: rtl/sha256_arbiter.sv
// Shares one SHA-256 block core among NUM_REQ requesters: one job at a time,
// with a watchdog that returns an error response if the core never finishes.
module sha256_arbiter
    import sha256_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*MSG_W-1:0] req_msg,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     core_start,
    output logic [MSG_W-1:0]         core_msg,
    input  logic                     core_done,
    input  logic [HASH_W-1:0]        core_hash,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [HASH_W-1:0]        resp_hash,
    output logic                     resp_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                start_q, start_d;
    logic [MSG_W-1:0]    msg_q, msg_d;
    logic                resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]     resp_id_q, resp_id_d;
    logic [HASH_W-1:0]   resp_hash_q, resp_hash_d;
    logic                resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0]  grant_s;
    logic [7:0]          grant_ext_s;
    logic [ID_W-1:0]     grant_idx_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant_s)
    );

    // Grants are only offered while no job is in flight.
    assign req_ready   = (state_q == ST_IDLE) ? grant_s : '0;
    assign grant_ext_s = 8'(grant_s);
    assign grant_idx_s = onehot_idx(grant_ext_s);

    assign core_start  = start_q;
    assign core_msg    = msg_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_hash   = resp_hash_q;
    assign resp_err    = resp_err_q;

    // Job sequencing: accept, pulse start, wait for done or timeout, respond.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        start_d      = 1'b0;
        msg_d        = msg_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_hash_d  = resp_hash_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_ready) begin
                    msg_d        = req_msg[int'(grant_idx_s)*MSG_W +: MSG_W];
                    resp_id_d    = grant_idx_s;
                    last_grant_d = grant_idx_s;
                    start_d      = 1'b1;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the timeout cycle still wins.
                if (core_done) begin
                    resp_hash_d  = core_hash;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    resp_hash_d  = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any job in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            start_q      <= 1'b0;
            msg_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_hash_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            msg_q        <= msg_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_hash_q  <= resp_hash_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_sha256_arbiter.sv
// Randomised bench for sha256_arbiter against a job-level reference model
// and a behavioural core with programmable completion latency.
module tb_sha256_arbiter;
    import sha256_pkg::*;

    localparam int NR = 4;
    localparam int TO = 16;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*24-1:0]  req_msg;
    logic [NR-1:0]     req_ready;
    logic              core_start;
    logic [23:0]       core_msg;
    logic              core_done;
    logic [255:0]      core_hash;
    logic              resp_valid;
    logic              resp_ready;
    logic [2:0]        resp_id;
    logic [255:0]      resp_hash;
    logic              resp_err;

    int          checks = 0;
    int          errors = 0;
    int          last_m = NR - 1;
    int          core_lat = 0;
    int          cd = 0;
    logic        model_done = 1'b0;
    logic        force_done = 1'b0;
    logic [23:0] model_msg = 24'h000000;

    sha256_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_msg    (req_msg),
        .req_ready  (req_ready),
        .core_start (core_start),
        .core_msg   (core_msg),
        .core_done  (core_done),
        .core_hash  (core_hash),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_hash  (resp_hash),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    // Stand-in digest: the real SHA-256 value for "abc", a mixing pattern otherwise.
    function automatic logic [255:0] hash_of(input logic [23:0] m);
        logic [31:0] w;
        if (m == 24'h616263) return ABC_DIGEST;
        w = {8'hA5, m} ^ 32'h9E3779B9;
        return {w, ~w, w + 32'd1, w ^ 32'h0F0F0F0F, {m, 8'h3C}, w, ~w, {8'h11, m}};
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    assign core_done = model_done | force_done;
    assign core_hash = hash_of(model_msg);

    // Core model: done pulses core_lat cycles after the start cycle; 0 = never.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            cd = 0;
            model_done = 1'b0;
        end else if (core_start) begin
            cd = core_lat;
            model_done = 1'b0;
            model_msg = core_msg;
        end else if (cd > 0) begin
            cd = cd - 1;
            model_done = (cd == 0);
        end else begin
            model_done = 1'b0;
        end
    end

    // Hard stop in case the bench itself deadlocks.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_job(input logic [NR-1:0] vld, input int lat, input int hold,
                           input bit use_abc, output int id);
        logic [23:0]  msgs [NR];
        logic [23:0]  exp_msg;
        logic [255:0] exp_hash;
        logic         exp_err;
        int           exp_n;
        int           n;
        bit           bad;
        for (int i = 0; i < NR; i++) msgs[i] = 24'($urandom);
        id = rr_pick(vld, last_m);
        if (use_abc) msgs[id] = 24'h616263;
        exp_msg  = msgs[id];
        exp_err  = !(lat >= 1 && lat <= TO);
        exp_n    = exp_err ? TO + 1 : lat + 1;
        exp_hash = exp_err ? 256'd0 : hash_of(exp_msg);
        for (int i = 0; i < NR; i++) req_msg[i*24 +: 24] = msgs[i];
        core_lat  = lat;
        req_valid = vld;
        #1;
        checks++;
        if (req_ready !== NR'(1 << id)) begin
            errors++;
            $display("FAIL grant: req_ready=%b expected %b", req_ready, NR'(1 << id));
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (core_start !== 1'b1 || core_msg !== exp_msg) begin
            errors++;
            $display("FAIL start: core_start=%b core_msg=%h expected 1 %h", core_start, core_msg, exp_msg);
        end
        n = 0;
        bad = 1'b0;
        while (resp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (core_start !== 1'b0 || req_ready !== '0 || core_msg !== exp_msg) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL busy: extra start, grant or core_msg change while job in flight (msg %h)", exp_msg);
        end
        checks++;
        if (n !== exp_n) begin
            errors++;
            $display("FAIL latency: resp_valid after %0d cycles expected %0d", n, exp_n);
        end
        checks++;
        if (resp_id !== 3'(id) || resp_err !== exp_err) begin
            errors++;
            $display("FAIL resp_id_err: id=%0d err=%b expected %0d %b", resp_id, resp_err, id, exp_err);
        end
        checks++;
        if (resp_hash !== exp_hash) begin
            errors++;
            $display("FAIL resp_hash: got %h expected %h", resp_hash, exp_hash);
        end
        for (int h = 0; h < hold; h++) begin
            req_valid = vld;
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== 3'(id) || resp_err !== exp_err ||
                resp_hash !== exp_hash || req_ready !== '0) begin
                errors++;
                $display("FAIL hold: cycle %0d valid=%b id=%0d err=%b req_ready=%b", h,
                         resp_valid, resp_id, resp_err, req_ready);
            end
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: resp_valid=%b expected 0", resp_valid);
        end
        last_m = id;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '1;
        req_msg = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || core_start !== 1'b0 || core_msg !== 24'h0 ||
            resp_id !== 3'd0 || resp_hash !== 256'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b start=%b msg=%h id=%0d err=%b",
                     resp_valid, core_start, core_msg, resp_id, resp_err);
        end
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: req_ready=%b expected 0001", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        last_m = NR - 1;
    endtask

    task automatic test_single();
        int id;
        run_job(4'b0001, 5, 0, 1'b1, id);
    endtask

    task automatic test_drop_before_grant();
        logic [NR-1:0] v;
        int e;
        for (int i = 0; i < 3; i++) begin
            v = NR'($urandom_range(1, 15));
            e = rr_pick(v, last_m);
            req_valid = v;
            #1;
            checks++;
            if (req_ready !== NR'(1 << e)) begin
                errors++;
                $display("FAIL drop_grant: req_ready=%b expected %b", req_ready, NR'(1 << e));
            end
            #1;
            req_valid = '0;
            @(negedge clk);
            checks++;
            if (core_start !== 1'b0 || req_ready !== '0) begin
                errors++;
                $display("FAIL drop_nochange: core_start=%b req_ready=%b expected 0 0", core_start, req_ready);
            end
        end
    endtask

    task automatic test_timeout();
        int id;
        run_job(NR'($urandom_range(1, 15)), 0, 0, 1'b0, id);
        run_job(NR'($urandom_range(1, 15)), $urandom_range(1, 15), 0, 1'b0, id);
    endtask

    task automatic test_done_on_timeout();
        int id;
        run_job(NR'($urandom_range(1, 15)), TO, 0, 1'b0, id);
    endtask

    task automatic test_backpressure();
        int id;
        run_job(NR'($urandom_range(1, 15)), 7, 10, 1'b0, id);
    endtask

    task automatic test_random();
        int id;
        for (int j = 0; j < 20; j++) begin
            run_job(NR'($urandom_range(1, 15)), $urandom_range(0, TO), $urandom_range(0, 3), 1'b0, id);
        end
    endtask

    task automatic test_reset_mid_job();
        bit bad;
        req_msg = {NR{24'($urandom)}};
        core_lat = 0;
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (core_start !== 1'b1) begin
            errors++;
            $display("FAIL midjob_start: core_start=%b expected 1", core_start);
        end
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || core_start !== 1'b0 || core_msg !== 24'h0 ||
            resp_id !== 3'd0 || resp_hash !== 256'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL midjob_reset: valid=%b start=%b msg=%h id=%0d err=%b",
                     resp_valid, core_start, core_msg, resp_id, resp_err);
        end
        @(negedge clk);
        rst = 1'b1;
        last_m = NR - 1;
        @(negedge clk);
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || core_start !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL late_done: resp_valid or core_start rose after stale done");
        end
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_grant: req_ready=%b expected 0001", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int order [5];
        int id;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        for (int j = 0; j < 5; j++) begin
            run_job('1, $urandom_range(1, 15), 0, 1'b0, id);
            order[j] = id;
        end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (order[j] !== exp_order[j]) begin
                errors++;
                $display("FAIL rr_order: job %0d served %0d expected %0d", j, order[j], exp_order[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_drop_before_grant();
        test_timeout();
        test_done_on_timeout();
        test_backpressure();
        test_random();
        test_reset_mid_job();
        test_round_robin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
